// File: rtl/vend_credit_if.sv
// Coin-acceptor, actuator and display-bank signals of the vending credit controller.
// The controller uses the slave modport; the environment driving coins uses master.
interface vend_credit_if #(
    parameter int CREDIT_W = 6
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                dispense;
    logic                change_nickel;
    logic                coin_reject;
    logic                busy;
    logic                reg_load;
    logic                reg_en;

    modport master (
        output coin_valid,
        output coin_type,
        output cancel,
        input  credit,
        input  dispense,
        input  change_nickel,
        input  coin_reject,
        input  busy,
        input  reg_load,
        input  reg_en
    );

    modport slave (
        input  coin_valid,
        input  coin_type,
        input  cancel,
        output credit,
        output dispense,
        output change_nickel,
        output coin_reject,
        output busy,
        output reg_load,
        output reg_en
    );
endinterface

// File: rtl/vend_credit_controller.sv
// Vending credit FSM: accumulates coins, vends one item at PRICE, refunds the rest as nickels.
// Every output is registered and derived from the next-state decision taken at the same edge.
module vend_credit_controller #(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 35,
    parameter int CREDIT_W   = 6
) (
    input  logic          Clk,
    input  logic          Clear,
    vend_credit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        REFUND  = 2'b11
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] DIME_C   = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(25);
    localparam logic [CREDIT_W:0]   MAX_C    = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_dispense;
    logic                r_changeNickel;
    logic                r_coinReject;
    logic                r_busy;
    logic                r_regLoad;
    logic                r_regEn;

    logic [CREDIT_W-1:0] w_coinValue;
    logic                w_coinLegal;
    logic [CREDIT_W:0]   w_sum;
    logic                w_accept;
    state_t              w_nextState;
    logic [CREDIT_W-1:0] w_nextCredit;
    logic                w_reject;

    always_comb begin
        w_coinValue = '0;
        w_coinLegal = 1'b1;
        case (bus.coin_type)
            2'b00:   w_coinValue = NICKEL_C;
            2'b01:   w_coinValue = DIME_C;
            2'b10:   w_coinValue = QUARTER_C;
            default: w_coinLegal = 1'b0;
        endcase
    end

    // One extra bit on the sum so the ceiling test cannot wrap.
    assign w_sum    = {1'b0, r_credit} + {1'b0, w_coinValue};
    assign w_accept = bus.coin_valid && w_coinLegal && !bus.cancel && (w_sum <= MAX_C);

    always_comb begin
        w_nextState  = r_state;
        w_nextCredit = r_credit;
        w_reject     = bus.coin_valid;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_reject     = 1'b0;
                    w_nextCredit = w_coinValue;
                    w_nextState  = (w_coinValue >= PRICE_C) ? VEND : COLLECT;
                end
            end
            COLLECT: begin
                if (bus.cancel) begin
                    w_nextState = REFUND;
                end else if (w_accept) begin
                    w_reject     = 1'b0;
                    w_nextCredit = w_sum[CREDIT_W-1:0];
                    w_nextState  = (w_sum[CREDIT_W-1:0] >= PRICE_C) ? VEND : COLLECT;
                end
            end
            VEND: begin
                w_nextCredit = r_credit - PRICE_C;
                w_nextState  = (r_credit == PRICE_C) ? IDLE : REFUND;
            end
            REFUND: begin
                if (r_credit <= NICKEL_C) begin
                    w_nextCredit = '0;
                    w_nextState  = IDLE;
                end else begin
                    w_nextCredit = r_credit - NICKEL_C;
                end
            end
            default: begin
                w_nextCredit = '0;
                w_nextState  = IDLE;
            end
        endcase
    end

    // Display bank reloads on any credit change and on return to IDLE so it tri-states.
    always_ff @(posedge Clk) begin
        if (Clear) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_dispense     <= 1'b0;
            r_changeNickel <= 1'b0;
            r_coinReject   <= 1'b0;
            r_busy         <= 1'b0;
            r_regLoad      <= 1'b0;
            r_regEn        <= 1'b0;
        end else begin
            r_state        <= w_nextState;
            r_credit       <= w_nextCredit;
            r_dispense     <= (w_nextState == VEND);
            r_changeNickel <= (w_nextState == REFUND);
            r_coinReject   <= w_reject;
            r_busy         <= (w_nextState == VEND) || (w_nextState == REFUND);
            r_regLoad      <= (w_nextCredit != r_credit) ||
                              ((w_nextState == IDLE) && (r_state != IDLE));
            r_regEn        <= (w_nextState != IDLE);
        end
    end

    assign bus.credit        = r_credit;
    assign bus.dispense      = r_dispense;
    assign bus.change_nickel = r_changeNickel;
    assign bus.coin_reject   = r_coinReject;
    assign bus.busy          = r_busy;
    assign bus.reg_load      = r_regLoad;
    assign bus.reg_en        = r_regEn;

endmodule

// File: tb/tb_vend_credit_controller.sv
// Scoreboard bench for vend_credit_controller: a credit/refund-count model predicts each
// cycle's outputs, and a separate monitor compares them with the DUT.
module tb_vend_credit_controller;

    localparam int PRICE      = 15;
    localparam int MAX_CREDIT = 35;
    localparam int CREDIT_W   = 6;

    logic Clk = 1'b0;
    logic Clear;

    always #5 Clk = ~Clk;

    vend_credit_if #(.CREDIT_W(CREDIT_W)) vif();

    vend_credit_controller #(
        .PRICE      (PRICE),
        .MAX_CREDIT (MAX_CREDIT),
        .CREDIT_W   (CREDIT_W)
    ) dut (
        .Clk   (Clk),
        .Clear (Clear),
        .bus   (vif)
    );

    typedef struct packed {
        logic [7:0] credit;
        logic       dispense;
        logic       changeNickel;
        logic       coinReject;
        logic       busy;
        logic       regLoad;
        logic       regEn;
    } outs_t;

    outs_t expQ[$];
    int    checksTotal  = 0;
    int    checksPassed = 0;
    int    cycleNo      = 0;

    // Model: credit in cents, whether the machine is vending now, and nickels still owed.
    int mCredit = 0;
    bit mVend   = 1'b0;
    int mRefund = 0;

    task automatic modelStep(input bit cv, input logic [1:0] ct, input bit cn, input bit clr);
        outs_t e;
        int    value;
        int    prevCredit;
        bit    prevIdle;
        bit    nowIdle;
        bit    reject;
        if (clr) begin
            mCredit = 0;
            mVend   = 1'b0;
            mRefund = 0;
            e       = '0;
        end else begin
            prevCredit = mCredit;
            prevIdle   = !mVend && (mRefund == 0) && (mCredit == 0);
            reject     = 1'b0;
            value      = (ct == 2'd0) ? 5 : (ct == 2'd1) ? 10 : (ct == 2'd2) ? 25 : 0;
            if (mVend) begin
                mCredit = mCredit - PRICE;
                mVend   = 1'b0;
                mRefund = mCredit / 5;
                reject  = cv;
            end else if (mRefund > 0) begin
                mCredit = mCredit - 5;
                mRefund = mRefund - 1;
                reject  = cv;
            end else if (cn && (mCredit > 0)) begin
                mRefund = mCredit / 5;
                reject  = cv;
            end else if (cv) begin
                if ((value != 0) && !cn && (mCredit + value <= MAX_CREDIT)) begin
                    mCredit = mCredit + value;
                    if (mCredit >= PRICE) mVend = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end
            nowIdle        = !mVend && (mRefund == 0) && (mCredit == 0);
            e.credit       = 8'(mCredit);
            e.dispense     = mVend;
            e.changeNickel = (mRefund > 0);
            e.coinReject   = reject;
            e.busy         = mVend || (mRefund > 0);
            e.regEn        = !nowIdle;
            e.regLoad      = (mCredit != prevCredit) || (nowIdle && !prevIdle);
        end
        expQ.push_back(e);
    endtask

    task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] exp);
        checksTotal++;
        if (act === exp) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycleNo, act, exp);
        end
    endtask

    task automatic checkOutput(input outs_t e);
        checkField("credit",        8'(vif.credit),        e.credit);
        checkField("dispense",      8'(vif.dispense),      8'(e.dispense));
        checkField("change_nickel", 8'(vif.change_nickel), 8'(e.changeNickel));
        checkField("coin_reject",   8'(vif.coin_reject),   8'(e.coinReject));
        checkField("busy",          8'(vif.busy),          8'(e.busy));
        checkField("reg_load",      8'(vif.reg_load),      8'(e.regLoad));
        checkField("reg_en",        8'(vif.reg_en),        8'(e.regEn));
    endtask

    task automatic applyStimulus(input bit cv, input logic [1:0] ct, input bit cn, input bit clr);
        @(negedge Clk);
        vif.coin_valid = cv;
        vif.coin_type  = ct;
        vif.cancel     = cn;
        Clear          = clr;
        @(posedge Clk);
        cycleNo++;
        modelStep(cv, ct, cn, clr);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    // Monitor: outputs settle just after each edge; compare against the oldest prediction.
    initial begin
        outs_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        vif.coin_valid = 1'b0;
        vif.coin_type  = 2'b00;
        vif.cancel     = 1'b0;
        Clear          = 1'b1;

        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);

        $display("[TB] three nickels");
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        idleCycles(4);

        $display("[TB] dime then quarter");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
        idleCycles(7);

        $display("[TB] dime then cancel");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
        idleCycles(4);

        $display("[TB] invalid coin in idle, nickel during refund");
        applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        idleCycles(3);

        $display("[TB] cancel with dime in collect");
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
        idleCycles(3);

        $display("[TB] clear during refund");
        applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
        idleCycles(4);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 2) == 0,
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 99) == 0);
        end
        idleCycles(8);

        @(negedge Clk);
        checkField("queue_drained", 8'(expQ.size()), 8'd0);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/vend_credit_controller.md
Name: vend_credit_controller

Overview:
- FSM controller for the vending machine: accepts coins, accumulates credit, dispenses one item at PRICE and returns excess or cancelled credit as nickels.
- Sequences the shared credit-display DFF bank through reg_load/reg_en (the bank tri-states when loaded with enable low).
- Sits between the coin acceptor front-end and the dispense/change actuators.
- All outputs are registered.

Parameters:
PRICE, 15, item price in cents; must be a multiple of 5 and no greater than MAX_CREDIT.
MAX_CREDIT, 35, credit ceiling in cents; a coin that would exceed it is rejected.
CREDIT_W, 6, credit width; must satisfy 2^CREDIT_W > MAX_CREDIT.

Ports:
Clk  in  1  system clock; all logic on rising edge.
Clear  in  1  synchronous active-high reset.
coin_valid  in  1  one-cycle strobe, coin present.
coin_type  in  2  00=nickel(5), 01=dime(10), 10=quarter(25), 11=invalid.
cancel  in  1  one-cycle strobe, user requests refund.
credit  out  CREDIT_W  current credit in cents.
dispense  out  1  high exactly one cycle per vend.
change_nickel  out  1  high one cycle per nickel returned.
coin_reject  out  1  one-cycle pulse, coin presented but not accepted.
busy  out  1  high in VEND and REFUND.
reg_load  out  1  load strobe to the display DFF bank.
reg_en  out  1  drive enable to the display DFF bank.

Behaviour:
- One clock, Clk. Clear is synchronous and active-high.
- Reset (Clear high at an edge): state=IDLE; credit, dispense, change_nickel, coin_reject, busy, reg_load and reg_en all 0. Clear overrides every other input, including mid-VEND or mid-REFUND. Credit is discarded; no refund is issued.
- Coin acceptance:
  - A coin is accepted only in IDLE or COLLECT, with coin_valid=1, coin_type!=11, credit+value<=MAX_CREDIT, and cancel=0.
  - Otherwise coin_valid=1 yields coin_reject=1 in the next cycle, with credit unchanged.
- Latency: a coin accepted at edge N is reflected in credit after edge N+1 (one cycle).
- IDLE:
  - Accepted coin: credit<=value.
  - Next state is VEND if value>=PRICE, else COLLECT.
  - cancel is ignored.
- COLLECT:
  - cancel=1: go to REFUND. Any coin in the same cycle is rejected; cancel wins.
  - Accepted coin: credit<=credit+value. Next state is VEND if the new credit>=PRICE, else stay in COLLECT.
- VEND (lasts one cycle):
  - dispense=1 (Moore output).
  - On exit: credit<=credit-PRICE. Next state is IDLE if the result is 0, else REFUND.
  - Coins and cancel are ignored; coins are rejected.
- REFUND:
  - change_nickel=1 every cycle.
  - credit<=credit-5 each cycle. When credit==5 in this cycle, the next state is IDLE (credit becomes 0).
  - Coins are rejected; cancel is ignored.
- busy=1 exactly when state is VEND or REFUND.
- Display bank:
  - reg_en=1 whenever state!=IDLE.
  - reg_load=1 for one cycle on every credit change and on every entry into IDLE, so the bank tri-states when idle.
- Arithmetic is unsigned. Underflow and overflow are impossible by construction; MAX_CREDIT guarantees this.
- Illegal state encodings recover to IDLE with credit=0.

Test Plan (PRICE=15, MAX_CREDIT=35):
1. Three accepted nickels -> credit 5, 10, 15; VEND one cycle after the third coin; dispense one cycle; credit 0; IDLE; zero change_nickel pulses.
2. Dime then quarter -> credit 10, then 35; VEND; dispense; credit 20; then four change_nickel cycles (20, 15, 10, 5, 0); IDLE; busy high for 5 cycles.
3. Dime then cancel -> two change_nickel pulses; credit 10, 5, 0; IDLE; dispense never high.
4. coin_type=11 in IDLE, and a nickel during REFUND -> coin_reject pulse next cycle each time; credit unchanged.
5. In COLLECT with credit 5, cancel and dime in the same cycle -> coin_reject=1; REFUND; exactly one change_nickel pulse.
6. Clear asserted during the second REFUND cycle of scenario 2 -> after the next edge, state IDLE and all outputs 0; no further change pulses.
